// File: rtl/uart_mmio_pkg.sv
// Register map and bit positions for the memory-mapped UART FIFO front-end.
package uart_mmio_pkg;

    localparam logic [3:0] OFF_STATUS = 4'h0;
    localparam logic [3:0] OFF_DATA   = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int unsigned ST_TX_NOT_FULL  = 0;
    localparam int unsigned ST_RX_NOT_EMPTY = 1;
    localparam int unsigned ST_TX_EMPTY     = 2;
    localparam int unsigned ST_RX_OVF       = 3;
    localparam int unsigned ST_TX_OVF       = 4;
    localparam int unsigned ST_TX_CNT_LSB   = 8;
    localparam int unsigned ST_RX_CNT_LSB   = 16;
    localparam int unsigned CNT_FIELD_W     = 8;

    localparam int unsigned CTRL_RX_IRQ_EN  = 0;
    localparam int unsigned CTRL_TXE_IRQ_EN = 1;
    localparam int unsigned CTRL_W          = 2;

endpackage

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// Single-clock FIFO; the parent guarantees push only when not full and pop only when not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;

    // Storage is not reset; only pointers and count define contents.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/uart_mmio_fifo.sv
// MMIO UART front-end: TX/RX byte FIFOs behind STATUS/DATA/CTRL registers with registered reads.
// Optional interrupt support (CTRL register, o_irq) is built when UART_MMIO_IRQ_EN is defined.
module uart_mmio_fifo
    import uart_mmio_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_sel,
    input  logic [3:0]      i_addr,
    input  logic            i_wr_en,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic            i_rd_en,
    output logic [XLEN-1:0] o_rd_data,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_valid,
    input  logic            i_tx_ready,
    input  logic [7:0]      i_rx_data,
    input  logic            i_rx_valid,
    output logic            o_rx_ready,
    output logic            o_irq
);

    localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

    logic                tx_full, tx_empty, tx_push, tx_pop;
    logic                rx_full, rx_empty, rx_push, rx_pop;
    logic [TX_CNT_W-1:0] tx_count;
    logic [RX_CNT_W-1:0] rx_count;
    logic [7:0]          tx_head, rx_head;
    logic                wr_status, wr_data, rd_data, rd_req, rx_arrive;
    logic                tx_drop, rx_drop;
    logic                tx_ovf_q, rx_ovf_q;
    logic                rx_ready_q;
    logic [XLEN-1:0]     status, rd_mux;
    logic                unused_wdata;

    assign wr_status = i_sel & i_wr_en & (i_addr == OFF_STATUS);
    assign wr_data   = i_sel & i_wr_en & (i_addr == OFF_DATA);
    assign rd_data   = i_sel & i_rd_en & (i_addr == OFF_DATA);
    assign rd_req    = i_sel & i_rd_en;
    assign rx_arrive = i_rx_valid & rx_ready_q;

    // Full/empty judged on pre-edge state, so a same-cycle pop never rescues a push into a full FIFO.
    assign tx_push = wr_data & ~tx_full;
    assign tx_drop = wr_data & tx_full;
    assign tx_pop  = ~tx_empty & i_tx_ready;
    assign rx_push = rx_arrive & ~rx_full;
    assign rx_drop = rx_arrive & rx_full;
    assign rx_pop  = rd_data & ~rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (tx_push),
        .push_data (i_wr_data[7:0]),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .head      (tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (rx_push),
        .push_data (i_rx_data),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .head      (rx_head)
    );

    assign o_tx_valid = ~tx_empty;
    assign o_tx_data  = tx_head;
    assign o_rx_ready = rx_ready_q;

    // Sticky overflow flags: a new drop wins over a coincident write-1-to-clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            tx_ovf_q   <= tx_drop | (tx_ovf_q & ~(wr_status & i_wr_data[ST_TX_OVF]));
            rx_ovf_q   <= rx_drop | (rx_ovf_q & ~(wr_status & i_wr_data[ST_RX_OVF]));
            rx_ready_q <= 1'b1;
        end
    end

    always_comb begin
        status                                 = '0;
        status[ST_TX_NOT_FULL]                 = ~tx_full;
        status[ST_RX_NOT_EMPTY]                = ~rx_empty;
        status[ST_TX_EMPTY]                    = tx_empty;
        status[ST_RX_OVF]                      = rx_ovf_q;
        status[ST_TX_OVF]                      = tx_ovf_q;
        status[ST_TX_CNT_LSB +: CNT_FIELD_W]   = CNT_FIELD_W'(tx_count);
        status[ST_RX_CNT_LSB +: CNT_FIELD_W]   = CNT_FIELD_W'(rx_count);
    end

`ifdef UART_MMIO_IRQ_EN
    logic [CTRL_W-1:0] ctrl_q;
    logic              irq_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (i_sel & i_wr_en & (i_addr == OFF_CTRL)) begin
                ctrl_q <= i_wr_data[CTRL_W-1:0];
            end
            irq_q <= (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) | (ctrl_q[CTRL_TXE_IRQ_EN] & tx_empty);
        end
    end

    assign o_irq = irq_q;
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            OFF_STATUS: rd_mux = status;
            OFF_DATA:   rd_mux = rx_empty ? '0 : XLEN'(rx_head);
`ifdef UART_MMIO_IRQ_EN
            OFF_CTRL:   rd_mux = XLEN'(ctrl_q);
`endif
            default:    rd_mux = '0;
        endcase
    end

    // Read data holds its value unless a selected read is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else if (rd_req) begin
            o_rd_data <= rd_mux;
        end
    end

    assign unused_wdata = ^i_wr_data[XLEN-1:8];

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed self-checking bench for uart_mmio_fifo (vector table plus hand-written corner sequences).
module tb_uart_mmio_fifo;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_sel;
    logic [3:0]  i_addr;
    logic        i_wr_en;
    logic [31:0] i_wr_data;
    logic        i_rd_en;
    logic [31:0] o_rd_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        o_irq;

    int checks = 0;
    int errors = 0;

    uart_mmio_fifo #(.XLEN(32), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sel      (i_sel),
        .i_addr     (i_addr),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (i_rd_en),
        .o_rd_data  (o_rd_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_irq      (o_irq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        sel;
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic        txr;
        logic        c_rd;
        logic [31:0] e_rd;
        logic        c_tx;
        logic        e_txv;
        logic [7:0]  e_txd;
    } vec_t;

    localparam int unsigned NVEC = 15;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1ns after the rising edge.
    task automatic cyc(input logic sel, input logic wr, input logic rd, input logic [3:0] addr,
                       input logic [31:0] wd, input logic rxv, input logic [7:0] rxd, input logic txr);
        i_sel      = sel;
        i_wr_en    = wr;
        i_rd_en    = rd;
        i_addr     = addr;
        i_wr_data  = wd;
        i_rx_valid = rxv;
        i_rx_data  = rxd;
        i_tx_ready = txr;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // sel wr rd addr wd txr | c_rd e_rd | c_tx e_txv e_txd
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'hC, 32'h0,  1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'hC, 32'h0,  1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h4, 32'h99, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'h4, 32'h41, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h41};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'h4, 32'h42, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h41};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'h4, 32'h43, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h41};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_0301, 1'b1, 1'b1, 8'h41};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h42};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'h43};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 4'h4, 32'h77, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 8'h77};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 8'h00};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 8'h00};

        i_rst_n    = 1'b0;
        i_sel      = 1'b0;
        i_wr_en    = 1'b0;
        i_rd_en    = 1'b0;
        i_addr     = 4'h0;
        i_wr_data  = 32'h0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        i_tx_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_rd_data",  o_rd_data, 32'h0);
        chk("reset_tx_valid", 32'(o_tx_valid), 32'h0);
        chk("reset_rx_ready", 32'(o_rx_ready), 32'h0);
        chk("reset_irq",      32'(o_irq), 32'h0);
        i_rst_n = 1'b1;
        idle();
        chk("post_reset_rx_ready", 32'(o_rx_ready), 32'h1);

        for (int i = 0; i < int'(NVEC); i++) begin
            cyc(tbl[i].sel, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, 1'b0, 8'h00, tbl[i].txr);
            if (tbl[i].c_rd) chk($sformatf("vec%0d_rd_data", i), o_rd_data, tbl[i].e_rd);
            if (tbl[i].c_tx) begin
                chk($sformatf("vec%0d_tx_valid", i), 32'(o_tx_valid), 32'(tbl[i].e_txv));
                if (tbl[i].e_txv) chk($sformatf("vec%0d_tx_data", i), 32'(o_tx_data), 32'(tbl[i].e_txd));
            end
        end

        // Asynchronous reset with a byte pending in TX.
        cyc(1'b1, 1'b1, 1'b0, 4'h4, 32'h11, 1'b0, 8'h00, 1'b0);
        chk("pre_reset_tx_valid", 32'(o_tx_valid), 32'h1);
        i_sel   = 1'b0;
        i_wr_en = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("midreset_tx_valid", 32'(o_tx_valid), 32'h0);
        chk("midreset_rx_ready", 32'(o_rx_ready), 32'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle();
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("after_reset_status", o_rd_data, 32'h0000_0005);

        // RX: 17 bytes with no reads; the 17th is dropped.
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 8'(i), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("rx_full_status", o_rd_data, 32'h0010_000F);
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 32'h8, 1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("w1c_vs_drop_status", o_rd_data, 32'h0010_000F);

        // Full: pop happens, incoming byte dropped.
        cyc(1'b1, 1'b0, 1'b1, 4'h4, 32'h0, 1'b1, 8'hBB, 1'b0);
        chk("full_rd_push_data", o_rd_data, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("full_rd_push_status", o_rd_data, 32'h000F_000F);
        // 15 entries: pop and push both land.
        cyc(1'b1, 1'b0, 1'b1, 4'h4, 32'h0, 1'b1, 8'hCC, 1'b0);
        chk("n15_rd_push_data", o_rd_data, 32'h0000_0001);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("n15_rd_push_status", o_rd_data, 32'h000F_000F);
        for (int i = 2; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 4'h4, 32'h0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("rx_drain_%0d", i), o_rd_data, 32'(i));
        end
        cyc(1'b1, 1'b0, 1'b1, 4'h4, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("rx_drain_cc", o_rd_data, 32'h0000_00CC);
        cyc(1'b1, 1'b0, 1'b1, 4'h4, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("rx_empty_read", o_rd_data, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("rx_empty_status", o_rd_data, 32'h0000_000D);

        // TX: 17 writes with the uart stalled; the 17th is dropped.
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 1'b0, 4'h4, 32'(i), 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("tx_full_status", o_rd_data, 32'h0000_1018);
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 32'h18, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("w1c_status", o_rd_data, 32'h0000_1000);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_drain_valid_%0d", i), 32'(o_tx_valid), 32'h1);
            chk($sformatf("tx_drain_data_%0d", i), 32'(o_tx_data), 32'(i));
            cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 8'h00, 1'b1);
        end
        chk("tx_drained_valid", 32'(o_tx_valid), 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("tx_drained_status", o_rd_data, 32'h0000_0005);

`ifdef UART_MMIO_IRQ_EN
        cyc(1'b1, 1'b1, 1'b0, 4'h8, 32'h1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'h8, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("ctrl_read", o_rd_data, 32'h0000_0001);
        chk("irq_idle", 32'(o_irq), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 8'h55, 1'b0);
        chk("irq_lag", 32'(o_irq), 32'h0);
        idle();
        chk("irq_set", 32'(o_irq), 32'h1);
        cyc(1'b1, 1'b0, 1'b1, 4'h4, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("irq_rx_data", o_rd_data, 32'h0000_0055);
        idle();
        chk("irq_clear", 32'(o_irq), 32'h0);
`else
        cyc(1'b1, 1'b1, 1'b0, 4'h8, 32'h3, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'h8, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("ctrl_read_disabled", o_rd_data, 32'h0000_0000);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 8'h55, 1'b0);
        idle();
        chk("irq_disabled", 32'(o_irq), 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 4'h4, 32'h0, 1'b0, 8'h00, 1'b0);
        chk("noirq_rx_data", o_rd_data, 32'h0000_0055);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
